// File: rtl/stump_sequencer_if.sv
// Bundle between the Stump sequencer and its environment (memory, ALU flags, decoder).
// The master side drives memory/flag inputs; the slave side (the sequencer) drives state outputs.
interface stump_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      mem_rdata;
    logic             mem_ready;
    logic             cc_en;
    logic [3:0]       flags_in;
    logic [1:0]       state;
    logic [15:0]      ir;
    logic [3:0]       cc;
    logic             advance;
    logic [CNT_W-1:0] icount;
    logic             halted;

    modport master (
        output mem_rdata, mem_ready, cc_en, flags_in,
        input  state, ir, cc, advance, icount, halted
    );

    modport slave (
        input  mem_rdata, mem_ready, cc_en, flags_in,
        output state, ir, cc, advance, icount, halted
    );
endinterface

// File: rtl/stump_sequencer.sv
// Stump control-path front end: FETCH -> EXECUTE [-> MEMORY] sequencing with IR, CC and icount.
// Defining STUMP_HALT_EN adds a HALT state entered by executing 16'hF1FF.
module stump_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    stump_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        MEMORY  = 2'b10
`ifdef STUMP_HALT_EN
        , HALT  = 2'b11
`endif
    } state_t;

    state_t           state_reg;
    logic [15:0]      ir_reg;
    logic [3:0]       cc_reg;
    logic [CNT_W-1:0] icount_reg;
    logic [CNT_W-1:0] icount_next;
    logic             is_mem_insn;
    logic             advance;

    assign icount_next = icount_reg + CNT_W'(1);
    assign is_mem_insn = (ir_reg[15:13] == 3'b110);

`ifdef STUMP_HALT_EN
    localparam logic [15:0] HALT_INSN = 16'hF1FF;
    logic halted_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= FETCH;
            ir_reg     <= 16'h0000;
            cc_reg     <= 4'b0000;
            icount_reg <= '0;
`ifdef STUMP_HALT_EN
            halted_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                FETCH: begin
                    if (bus.mem_ready) begin
                        ir_reg    <= bus.mem_rdata;
                        state_reg <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (bus.cc_en) begin
                        cc_reg <= bus.flags_in;
                    end
`ifdef STUMP_HALT_EN
                    if (ir_reg == HALT_INSN) begin
                        state_reg  <= HALT;
                        icount_reg <= icount_next;
                        halted_reg <= 1'b1;
                    end else
`endif
                    if (is_mem_insn) begin
                        state_reg <= MEMORY;
                    end else begin
                        state_reg  <= FETCH;
                        icount_reg <= icount_next;
                    end
                end
                MEMORY: begin
                    if (bus.mem_ready) begin
                        state_reg  <= FETCH;
                        icount_reg <= icount_next;
                    end
                end
`ifdef STUMP_HALT_EN
                HALT: begin
                    // Parked until reset; every register holds.
                    state_reg <= HALT;
                end
`endif
                default: begin
                    // Unreachable encoding: recover to FETCH without touching IR/CC/count.
                    state_reg <= FETCH;
                end
            endcase
        end
    end

    always_comb begin
        advance = 1'b0;
        case (state_reg)
            FETCH, MEMORY: advance = bus.mem_ready;
            EXECUTE:       advance = 1'b1;
            default:       advance = 1'b0;
        endcase
    end

    assign bus.state   = state_reg;
    assign bus.ir      = ir_reg;
    assign bus.cc      = cc_reg;
    assign bus.icount  = icount_reg;
    assign bus.advance = advance;
`ifdef STUMP_HALT_EN
    assign bus.halted  = halted_reg;
`else
    assign bus.halted  = 1'b0;
`endif
endmodule

// File: tb/tb_stump_sequencer.sv
// Directed bench for stump_sequencer: a reference model pushes expected post-edge state into a
// scoreboard queue; a second instance with CNT_W=4 shares the stimulus to exercise icount wrap.
module tb_stump_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stump_sequencer_if #(.CNT_W(16)) bus ();
    stump_sequencer_if #(.CNT_W(4))  bus4 ();

    assign bus4.mem_rdata = bus.mem_rdata;
    assign bus4.mem_ready = bus.mem_ready;
    assign bus4.cc_en     = bus.cc_en;
    assign bus4.flags_in  = bus.flags_in;

    stump_sequencer #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    stump_sequencer #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    typedef struct {
        logic [1:0]  state;
        logic [15:0] ir;
        logic [3:0]  cc;
        logic [15:0] icount;
        logic        halted;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;

    logic [1:0]  m_state;
    logic [15:0] m_ir;
    logic [3:0]  m_cc;
    logic [15:0] m_cnt;
    logic        m_halted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state  = 2'b00;
        m_ir     = 16'h0000;
        m_cc     = 4'b0000;
        m_cnt    = 16'd0;
        m_halted = 1'b0;
    endtask

    task automatic model_step(input logic rdy, input logic [15:0] rd, input logic ce,
                              input logic [3:0] fl);
        case (m_state)
            2'b00: if (rdy) begin m_ir = rd; m_state = 2'b01; end
            2'b01: begin
                if (ce) m_cc = fl;
`ifdef STUMP_HALT_EN
                if (m_ir == 16'hF1FF) begin
                    m_state = 2'b11; m_cnt = m_cnt + 16'd1; m_halted = 1'b1;
                end else
`endif
                if (m_ir[15:13] == 3'b110) m_state = 2'b10;
                else begin m_state = 2'b00; m_cnt = m_cnt + 16'd1; end
            end
            2'b10: if (rdy) begin m_state = 2'b00; m_cnt = m_cnt + 16'd1; end
            default: ;
        endcase
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic rdy, input logic [15:0] rd, input logic ce,
                         input logic [3:0] fl);
        exp_t e;
        logic exp_adv;
        bus.mem_ready = rdy;
        bus.mem_rdata = rd;
        bus.cc_en     = ce;
        bus.flags_in  = fl;
        #1;
        case (m_state)
            2'b00, 2'b10: exp_adv = rdy;
            2'b01:        exp_adv = 1'b1;
            default:      exp_adv = 1'b0;
        endcase
        check("advance", 32'(bus.advance), 32'(exp_adv));
        model_step(rdy, rd, ce, fl);
        e = '{m_state, m_ir, m_cc, m_cnt, m_halted};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("state",   32'(bus.state),   32'(e.state));
        check("ir",      32'(bus.ir),      32'(e.ir));
        check("cc",      32'(bus.cc),      32'(e.cc));
        check("icount",  32'(bus.icount),  32'(e.icount));
        check("icount4", 32'(bus4.icount), 32'(e.icount[3:0]));
        check("halted",  32'(bus.halted),  32'(e.halted));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'h0000;
        bus.cc_en     = 1'b0;
        bus.flags_in  = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_state",  32'(bus.state),  32'h0);
        check("rst_ir",     32'(bus.ir),     32'h0);
        check("rst_cc",     32'(bus.cc),     32'h0);
        check("rst_icount", 32'(bus.icount), 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        rst_n = 1'b1;

        // Test 1: plain instruction, two-cycle latency.
        cycle(1'b1, 16'h0123, 1'b0, 4'h0);
        check("t1_ir", 32'(bus.ir), 32'h0123);
        check("t1_state_exec", 32'(bus.state), 32'h1);
        cycle(1'b0, 16'h0000, 1'b0, 4'h0);
        check("t1_icount", 32'(bus.icount), 32'd1);

        // Test 2: load with two wait states in MEMORY; mem_ready ignored in EXECUTE.
        cycle(1'b0, 16'hAAAA, 1'b0, 4'h0);
        cycle(1'b1, 16'hC000, 1'b0, 4'h0);
        cycle(1'b1, 16'h5555, 1'b0, 4'h0);
        check("t2_mem", 32'(bus.state), 32'h2);
        cycle(1'b0, 16'h0000, 1'b0, 4'h0);
        cycle(1'b0, 16'h0000, 1'b0, 4'h0);
        check("t2_held", 32'(bus.state), 32'h2);
        cycle(1'b1, 16'h7777, 1'b0, 4'h0);
        check("t2_fetch", 32'(bus.state), 32'h0);
        check("t2_icount", 32'(bus.icount), 32'd2);
        check("t2_ir_kept", 32'(bus.ir), 32'hC000);
        // Store-class opcode 110 and non-memory 111 neighbour.
        cycle(1'b1, 16'hDABC, 1'b0, 4'h0);
        cycle(1'b0, 16'h0000, 1'b0, 4'h0);
        cycle(1'b1, 16'h0000, 1'b0, 4'h0);
        cycle(1'b1, 16'hE000, 1'b0, 4'h0);
        cycle(1'b0, 16'h0000, 1'b0, 4'h0);
        check("t2_e000_fetch", 32'(bus.state), 32'h0);

        // Test 3: cc_en only honoured in EXECUTE.
        cycle(1'b1, 16'h0040, 1'b1, 4'b0101);
        check("t3_cc_fetch", 32'(bus.cc), 32'h0);
        cycle(1'b0, 16'h0000, 1'b1, 4'b1010);
        check("t3_cc_exec", 32'(bus.cc), 32'hA);
        cycle(1'b0, 16'h0000, 1'b1, 4'b0011);
        check("t3_cc_stall", 32'(bus.cc), 32'hA);

        // Test 4: asynchronous reset mid-MEMORY.
        cycle(1'b1, 16'hC000, 1'b0, 4'h0);
        cycle(1'b0, 16'h0000, 1'b1, 4'hF);
        cycle(1'b0, 16'h0000, 1'b1, 4'h3);
        check("t4_pre_cc", 32'(bus.cc), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_state",   32'(bus.state),   32'h0);
        check("t4_ir",      32'(bus.ir),      32'h0);
        check("t4_cc",      32'(bus.cc),      32'h0);
        check("t4_icount",  32'(bus.icount),  32'h0);
        check("t4_icount4", 32'(bus4.icount), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Test 5: 16 retirements wrap the 4-bit counter.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 16'h1000 + 16'(i), 1'b0, 4'h0);
            cycle(1'b1, 16'h0000, 1'b0, 4'h0);
            if (i == 14) check("t5_cnt4_15", 32'(bus4.icount), 32'd15);
        end
        check("t5_cnt4_wrap", 32'(bus4.icount), 32'd0);
        check("t5_cnt16", 32'(bus.icount), 32'd16);

        // Test 6: branch-never 16'hF1FF.
        cycle(1'b1, 16'hF1FF, 1'b0, 4'h0);
        cycle(1'b1, 16'h0000, 1'b0, 4'h0);
`ifdef STUMP_HALT_EN
        check("t6_halt_state", 32'(bus.state), 32'h3);
        check("t6_halted", 32'(bus.halted), 32'h1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 16'h1234 + 16'(i), 1'b1, 4'(i));
        end
        check("t6_held_state", 32'(bus.state), 32'h3);
        check("t6_held_ir", 32'(bus.ir), 32'hF1FF);
`else
        check("t6_state", 32'(bus.state), 32'h0);
        check("t6_halted", 32'(bus.halted), 32'h0);
        cycle(1'b1, 16'h0001, 1'b0, 4'h0);
        cycle(1'b1, 16'h0000, 1'b0, 4'h0);
`endif
        check("t6_icount", 32'(bus.icount), 32'(m_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
